// File: rtl/adder_pipe_pkg.sv
// Shared constants, mode type and elaboration helper for the generic pipelined adder.
package adder_pipe_pkg;

  localparam int MAX_STAGES = 8;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } adder_op_e;

  // Returns 0 for a non-positive stage count so range checks never divide by zero.
  function automatic int chunk_width(input int width, input int stages);
    if (stages <= 0) return 0;
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_pipe_slice.sv
// One stage of adder_pipe_gen: CW-bit add/sub with registered partial sum and carry.
// With ADDER_PIPE_OVF_EN defined, the MSB slice also registers signed overflow.
module adder_pipe_slice
  import adder_pipe_pkg::*;
#(
  parameter int CW = 16
`ifdef ADDER_PIPE_OVF_EN
  , parameter bit IS_MSB = 1'b0
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  adder_op_e     op,
  input  logic          cin,
  output logic [CW-1:0] sum_q,
  output logic          cout_q
`ifdef ADDER_PIPE_OVF_EN
  , output logic        ovf_q
`endif
);

  logic [CW-1:0] b_eff;
  logic [CW-1:0] sum_d;
  logic          cout_d;

  always_comb begin
    b_eff           = (op == OP_SUB) ? ~b : b;
    {cout_d, sum_d} = {1'b0, a} + {1'b0, b_eff} + {{CW{1'b0}}, cin};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (en) begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

`ifdef ADDER_PIPE_OVF_EN
  logic ovf_d;

  // The carry into the MSB is recovered as a ^ b ^ sum at that bit position.
  always_comb begin
    ovf_d = IS_MSB ? (a[CW-1] ^ b_eff[CW-1] ^ sum_d[CW-1] ^ cout_d) : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     ovf_q <= 1'b0;
    else if (en) ovf_q <= ovf_d;
  end
`endif

endmodule

// File: rtl/adder_pipe_gen.sv
// Parametrised pipelined adder/subtractor: one CW-bit chunk per stage, operands skewed in,
// results deskewed out, whole-pipe stall on out_ready. ADDER_PIPE_OVF_EN adds the ovf output.
module adder_pipe_gen
  import adder_pipe_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op0,
  input  logic [WIDTH-1:0] op1,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_PIPE_OVF_EN
  , output logic           ovf
`endif
);

  localparam int CW = chunk_width(WIDTH, STAGES);

  if (STAGES < 1 || STAGES > MAX_STAGES || CW * STAGES != WIDTH) begin : g_param_check
    $error("adder_pipe_gen: WIDTH=%0d STAGES=%0d is not a legal configuration", WIDTH, STAGES);
  end

  logic              en;
  adder_op_e         op_in;
  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] carry_s;
  logic [WIDTH-1:0]  sum_aligned;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;

  assign en        = out_ready || !out_valid_q;
  assign in_ready  = en;
  assign op_in     = sub ? OP_SUB : OP_ADD;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

`ifdef ADDER_PIPE_OVF_EN
  logic [STAGES-1:0] ovf_s;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_chunk
    logic [2*CW:0]  vec_in;
    logic [2*CW:0]  vec_stage;
    logic           cin;
    logic [CW-1:0]  part_sum;

    // Each skew entry carries the mode bit alongside this chunk's operands.
    assign vec_in = {op_in, op1[k*CW +: CW], op0[k*CW +: CW]};

    if (k == 0) begin : g_first
      assign vec_stage = vec_in;
      assign cin       = vec_stage[2*CW];
    end else begin : g_skew
      logic [2*CW:0] skew_q [k];
      logic [2*CW:0] skew_d [k];

      always_comb begin
        skew_d[0] = vec_in;
        for (int j = 1; j < k; j++) skew_d[j] = skew_q[j-1];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst)     skew_q <= '{default: '0};
        else if (en) skew_q <= skew_d;
      end

      assign vec_stage = skew_q[k-1];
      assign cin       = carry_s[k-1];
    end

    adder_pipe_slice #(
      .CW(CW)
`ifdef ADDER_PIPE_OVF_EN
      , .IS_MSB(k == STAGES - 1)
`endif
    ) u_slice (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .a      (vec_stage[CW-1:0]),
      .b      (vec_stage[2*CW-1:CW]),
      .op     (adder_op_e'(vec_stage[2*CW])),
      .cin    (cin),
      .sum_q  (part_sum),
      .cout_q (carry_s[k])
`ifdef ADDER_PIPE_OVF_EN
      , .ovf_q (ovf_s[k])
`endif
    );

    if (k == STAGES - 1) begin : g_last
      assign sum_aligned[k*CW +: CW] = part_sum;
    end else begin : g_deskew
      localparam int D = STAGES - 1 - k;
      logic [CW-1:0] deskew_q [D];
      logic [CW-1:0] deskew_d [D];

      always_comb begin
        deskew_d[0] = part_sum;
        for (int j = 1; j < D; j++) deskew_d[j] = deskew_q[j-1];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst)     deskew_q <= '{default: '0};
        else if (en) deskew_q <= deskew_d;
      end

      assign sum_aligned[k*CW +: CW] = deskew_q[D-1];
    end
  end

  always_comb begin
    valid_d     = valid_q << 1;
    valid_d[0]  = in_valid;
    out_valid_d = valid_q[STAGES-1];
    sum_d       = sum_aligned;
    cout_d      = carry_s[STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
    end else if (en) begin
      valid_q     <= valid_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
    end
  end

`ifdef ADDER_PIPE_OVF_EN
  logic ovf_q, ovf_d;

  // Only the MSB slice drives a non-zero overflow bit.
  always_comb begin
    ovf_d = |ovf_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     ovf_q <= 1'b0;
    else if (en) ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_adder_pipe_gen.sv
// Self-checking bench for adder_pipe_gen at WIDTH=64, STAGES=4.
// The ovf output is connected and checked only when ADDER_PIPE_OVF_EN is defined.
`timescale 1ns/1ps
module tb_adder_pipe_gen;

  localparam int WIDTH  = 64;
  localparam int STAGES = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op0;
  logic [WIDTH-1:0] op1;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef ADDER_PIPE_OVF_EN
  logic             ovf;
`endif

  adder_pipe_gen #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op0       (op0),
    .op1       (op1),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef ADDER_PIPE_OVF_EN
    , .ovf     (ovf)
`endif
  );

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    int               acc;
    int               stl;
    bit               seen;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   stalls = 0;

  logic [WIDTH-1:0] stream_a [8] = '{64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000,
                                     64'h8000_0000_0000_0001, 64'h0000_0000_0000_FFFF,
                                     64'hDEAD_BEEF_CAFE_F00D, 64'h7FFF_FFFF_FFFF_FFFF,
                                     64'h0000_0000_0000_0000, 64'h1234_5678_0000_0000};
  logic [WIDTH-1:0] stream_b [8] = '{64'hFEDC_BA98_7654_3210, 64'h0001_FFFF_0001_FFFF,
                                     64'h8000_0000_0000_0001, 64'h0000_0000_0001_0000,
                                     64'h1111_2222_3333_4444, 64'hFFFF_FFFF_FFFF_FFFF,
                                     64'h0000_0000_0000_0001, 64'h1234_5678_0000_0001};
  logic             stream_s [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain wide arithmetic; subtract carry means "no borrow".
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
    exp_t e;
    if (!s) begin
      {e.cout, e.sum} = {1'b0, a} + {1'b0, b};
      e.ovf = (a[WIDTH-1] == b[WIDTH-1]) && (e.sum[WIDTH-1] != a[WIDTH-1]);
    end else begin
      e.sum  = a - b;
      e.cout = (a >= b);
      e.ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (e.sum[WIDTH-1] != a[WIDTH-1]);
    end
    e.acc  = 0;
    e.stl  = 0;
    e.seen = 1'b0;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
    bit done;
    done     = 1'b0;
    op0      = a;
    op1      = b;
    sub      = s;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        done = 1'b1;
      end
    end
    #1;
    in_valid = 1'b0;
    if (!done) checkOutput("accept_timeout", 64'(done), 64'd1);
  endtask

  task automatic directedVector(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic s, input logic [WIDTH-1:0] exp_sum, input logic exp_cout,
                                input logic exp_ovf);
    int acc_cyc;
    bit got;
    applyStimulus(a, b, s);
    acc_cyc = cyc;
    got     = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    checkOutput({name, "_seen"}, 64'(got), 64'd1);
    if (got) begin
      checkOutput({name, "_latency"}, 64'(cyc - acc_cyc), 64'd4);
      checkOutput({name, "_sum"}, sum, exp_sum);
      checkOutput({name, "_cout"}, 64'(cout), 64'(exp_cout));
`ifdef ADDER_PIPE_OVF_EN
      checkOutput({name, "_ovf"}, 64'(ovf), 64'(exp_ovf));
`else
      if (exp_ovf === 1'bx) $display("[TB] note: %s has unknown ovf expectation", name);
`endif
    end
    @(posedge clk);
    #1;
  endtask

  // Compare process: every cycle outputs are meaningful they must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      checkOutput("in_ready_rule", 64'(in_ready), 64'(out_ready || !out_valid));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_out_valid", 64'(out_valid), 64'd0);
        end else begin
          e = exp_q[0];
          checkOutput("model_sum", sum, e.sum);
          checkOutput("model_cout", 64'(cout), 64'(e.cout));
`ifdef ADDER_PIPE_OVF_EN
          checkOutput("model_ovf", 64'(ovf), 64'(e.ovf));
`endif
          if (!e.seen) begin
            checkOutput("model_latency", 64'(cyc - e.acc - (stalls - e.stl)), 64'(STAGES));
            exp_q[0].seen = 1'b1;
          end
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (out_valid && !out_ready) stalls++;
      if (in_valid && in_ready) begin
        e     = model(op0, op1, sub);
        e.acc = cyc + 1;
        e.stl = stalls;
        exp_q.push_back(e);
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit drained;
    in_valid  = 1'b0;
    op0       = '0;
    op1       = '0;
    sub       = 1'b0;
    out_ready = 1'b1;
    rst       = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_sum", sum, 64'd0);
    checkOutput("reset_cout", 64'(cout), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
`ifdef ADDER_PIPE_OVF_EN
    checkOutput("reset_ovf", 64'(ovf), 64'd0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] directed vectors");
    directedVector("add_5_7", 64'd5, 64'd7, 1'b0, 64'd12, 1'b0, 1'b0);
    directedVector("add_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0);
    directedVector("sub_3_5", 64'd3, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    directedVector("sub_5_3", 64'd5, 64'd3, 1'b1, 64'd2, 1'b1, 1'b0);
    directedVector("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    directedVector("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

    $display("[TB] streaming with mid-stream stall");
    fork
      begin
        for (int i = 0; i < 8; i++) applyStimulus(stream_a[i], stream_b[i], stream_s[i]);
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        #1 checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
        checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join

    drained = 1'b0;
    for (int i = 0; i < 30 && !drained; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) drained = 1'b1;
    end
    checkOutput("stream_drained", 64'(exp_q.size()), 64'd0);
    #1;

    $display("[TB] asynchronous reset mid-operation");
    applyStimulus(64'd100, 64'd200, 1'b0);
    applyStimulus(64'd300, 64'd400, 1'b0);
    applyStimulus(64'd500, 64'd50, 1'b1);
    repeat (2) @(posedge clk);
    #3;
    checkOutput("pre_reset_out_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    checkOutput("async_reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("async_reset_sum", sum, 64'd0);
    checkOutput("async_reset_cout", 64'(cout), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    directedVector("post_reset", 64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF, 1'b0,
                   64'h0000_0001_FFFF_FFFF, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    checkOutput("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
